edf_arbiter: RTL
================

// Module: edf_arbiter
// PURPOSE
//  Sits directly downstream of the gateway_cell array. Scans the per-source
//  (ip, deadline) pairs sequentially and selects the pending source with the
//  earliest absolute deadline (EDF). Offers the winner to the core over a
//  valid/ready handshake, then pulses claim back to the winning gateway cell.
// PARAMETERS
//  NSource  8                   number of interrupt sources / gateway cells
//  TsWidth  64                  deadline and mtime width, in bits
//  IdWidth  $clog2(NSource)     source index width (derived, not overridable)
// PORTS
//  clk_i        in   1                 clock
//  rst_i        in   1                 synchronous reset, active-high
//  mtime_i      in   64                current machine time
//  ip_i         in   NSource           pending flags from the gateway cells
//  dl_i         in   NSource*TsWidth   deadlines from gateway cells; source k in [k*TsWidth +: TsWidth]
//  irq_ready_i  in   1                 core accepts the offered interrupt
//  irq_valid_o  out  1                 winner offered to the core
//  irq_id_o     out  IdWidth           index of the winner
//  irq_dl_o     out  TsWidth           deadline of the winner
//  irq_late_o   out  1                 winner deadline < mtime_i at scan end
//  claim_o      out  NSource           one-hot claim pulse to the gateway cells
// BEHAVIOUR
//  Clock and reset: single clock clk_i; rst_i is synchronous and active-high.
//  Reset: state=IDLE; every output 0; scan index, best id and best dl cleared. Applies at the next
//   edge from any state, including mid-SCAN and OFFER; a pending handshake is discarded, no claim.
//  FSM states: IDLE, SCAN, OFFER, CLAIM.
//   IDLE : if |ip_i, go to SCAN with idx=0, best_vld=0. Otherwise stay in IDLE.
//   SCAN : one source per cycle, idx = 0..NSource-1.
//          Source idx is taken if ip_i[idx] && (!best_vld || dl_i[idx] < best_dl).
//          Compare is unsigned and strictly-less, so on equal deadlines the lower index wins.
//          After idx=NSource-1: best_vld -> OFFER; else -> IDLE (every source dropped).
//          late is registered as (best_dl < mtime_i) on the transition to OFFER.
//   OFFER: irq_valid_o=1. id, dl and late are held stable until handshake or withdraw.
//          valid && irq_ready_i -> CLAIM.
//          If ip_i[best_id] drops while not accepted: withdraw. irq_valid_o goes to 0 and
//          the state goes to IDLE. Handshake has priority over withdraw in the same cycle.
//   CLAIM: claim_o = one-hot(best_id) for exactly 1 cycle, irq_valid_o=0, then IDLE.
//          The gateway clears ip_q on that edge, so IDLE never rescans a stale ip.
//  Latency: ip_i seen in IDLE at cycle t -> irq_valid_o=1 at cycle t+1+NSource.
//           Handshake at cycle h -> claim_o at cycle h+1 -> IDLE at cycle h+2.
//  No preemption: a newly pending, earlier source during OFFER waits for the next scan.
//  A source that asserts ip mid-SCAN is included only if idx has not yet passed it.
//  irq_id_o and irq_dl_o are 0 whenever irq_valid_o=0; claim_o is 0 outside CLAIM.
//  All outputs are registered (no combinational path from an input to an output).
// STRUCTURE
//  edf_pkg: typedef enum logic [1:0] edf_state_e {IDLE, SCAN, OFFER, CLAIM}.
//  edf_pkg: localparam TsWidthDefault = 64.
//  edf_pkg: function edf_earlier(a, b), the unsigned strict-less compare shared with later stages.
//  No sub-module. FSM, scan counter, best-candidate registers and a dl_i mux in one module.
// TESTING
//  1 Single source: ip[3]=1, dl[3]=100, NSource=8 -> valid at t+9, id=3, dl=100.
//    Ready=1 -> claim_o=8'h08 for 1 cycle.
//  2 Multiple sources: ip[1,4,6]=1, dl=500/200/300 -> id=4, dl=200.
//    After the claim, rescan -> id=6, then id=1.
//  3 Tie: ip[2,5]=1, both dl=50 -> id=2.
//  4 Withdraw: in OFFER with ready=0, drop ip[best] -> valid=0 next cycle, state IDLE, no claim.
//  5 Late flag: dl=10, mtime_i=20 at scan end -> irq_late_o=1.
//    dl=30, mtime_i=20 -> irq_late_o=0.
//  6 Reset mid-operation: assert rst_i mid-SCAN, and again in OFFER with ready=1
//    -> all outputs 0 next cycle, no claim_o pulse.

Source files
------------

// File: rtl/edf_pkg.sv
// edf_pkg: shared FSM state type, default timestamp width and EDF deadline compare
package edf_pkg;

    typedef enum logic [1:0] {IDLE, SCAN, OFFER, CLAIM} edf_state_e;

    localparam int TsWidthDefault = 64;

    // Unsigned strict-less: on equal deadlines the incumbent (lower index) keeps the slot
    function automatic logic edf_earlier(input logic [TsWidthDefault-1:0] a,
                                         input logic [TsWidthDefault-1:0] b);
        return a < b;
    endfunction

endpackage

// File: rtl/edf_arbiter.sv
// edf_arbiter: sequential earliest-deadline-first selection over gateway cells, offered via valid/ready then claimed
//   clk_i/rst_i   clock, synchronous active-high reset
//   mtime_i       current machine time, used for the late flag
//   ip_i, dl_i    per-source pending flags and deadlines (source k at [k*TsWidth +: TsWidth])
//   irq_ready_i   core accepts the offer
//   irq_valid_o, irq_id_o, irq_dl_o, irq_late_o   offered winner (id/dl/late zero when not valid)
//   claim_o       one-hot claim pulse back to the winning gateway cell
module edf_arbiter
    import edf_pkg::*;
#(
    parameter int NSource = 8,
    parameter int TsWidth = TsWidthDefault
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic [TsWidth-1:0]           mtime_i,
    input  logic [NSource-1:0]           ip_i,
    input  logic [NSource*TsWidth-1:0]   dl_i,
    input  logic                         irq_ready_i,
    output logic                         irq_valid_o,
    output logic [$clog2(NSource)-1:0]   irq_id_o,
    output logic [TsWidth-1:0]           irq_dl_o,
    output logic                         irq_late_o,
    output logic [NSource-1:0]           claim_o
);

    localparam int IdWidth = $clog2(NSource);

    edf_state_e         state_q, state_d;
    logic [IdWidth-1:0] idx_q, idx_d;
    logic [IdWidth-1:0] best_id_q, best_id_d;
    logic [TsWidth-1:0] best_dl_q, best_dl_d;
    logic               best_vld_q, best_vld_d;
    logic               late_q, late_d;
    logic [TsWidth-1:0] cur_dl;
    logic               take;

    always_comb begin
        cur_dl     = dl_i[idx_q*TsWidth +: TsWidth];
        take       = ip_i[idx_q] && (!best_vld_q || edf_earlier(cur_dl, best_dl_q));
        state_d    = state_q;
        idx_d      = idx_q;
        best_id_d  = best_id_q;
        best_dl_d  = best_dl_q;
        best_vld_d = best_vld_q;
        late_d     = late_q;
        unique case (state_q)
            IDLE: begin
                if (|ip_i) begin
                    state_d    = SCAN;
                    idx_d      = '0;
                    best_vld_d = 1'b0;
                end
            end
            SCAN: begin
                if (take) begin
                    best_id_d  = idx_q;
                    best_dl_d  = cur_dl;
                    best_vld_d = 1'b1;
                end
                if (idx_q == IdWidth'(NSource - 1)) begin
                    // late uses the final winner, including the last source just examined
                    state_d = best_vld_d ? OFFER : IDLE;
                    late_d  = edf_earlier(best_dl_d, mtime_i);
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            OFFER: begin
                // handshake beats withdraw when both happen in the same cycle
                if (irq_ready_i) state_d = CLAIM;
                else if (!ip_i[best_id_q]) state_d = IDLE;
            end
            CLAIM: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            best_id_q  <= '0;
            best_dl_q  <= '0;
            best_vld_q <= 1'b0;
            late_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            best_id_q  <= best_id_d;
            best_dl_q  <= best_dl_d;
            best_vld_q <= best_vld_d;
            late_q     <= late_d;
        end
    end

    assign irq_valid_o = state_q == OFFER;
    assign irq_id_o    = irq_valid_o ? best_id_q : '0;
    assign irq_dl_o    = irq_valid_o ? best_dl_q : '0;
    assign irq_late_o  = irq_valid_o && late_q;
    assign claim_o     = (state_q == CLAIM) ? (NSource'(1) << best_id_q) : '0;

endmodule
